alu_mul_sequencer: RTL

//  Multi-cycle 8x8 unsigned shift-and-add multiplier that uses the shared combinational ALU as its adder.

---
 rtl/alu_mul_sequencer.sv | 108 ++++++++++
 1 files changed

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned shift-and-add multiplier that borrows the shared ALU as its adder.
// Each granted STEP cycle adds (or passes) the running high half and shifts the accumulator right.
module alu_mul_sequencer #(
  parameter int          WIDTH      = 8,
  parameter logic [3:0]  MODE_ADD   = 4'b0000,
  parameter logic [3:0]  MODE_PASS  = 4'b0011,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 prod_zero,
  output logic                 alu_req,
  input  logic                 alu_gnt,
  output logic                 alu_e,
  output logic [3:0]           alu_mode,
  output logic [WIDTH-1:0]     alu_op1,
  output logic [WIDTH-1:0]     alu_op2,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic [3:0]           alu_flags
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STEP   = 2'd1;
  localparam logic [1:0] DONE_S = 2'd2;

  logic [1:0]         state;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [CW-1:0]      cnt;

  logic               carry;
  logic [2*WIDTH-1:0] next_acc;
  logic [2*WIDTH-1:0] final_acc;
  logic [CW-1:0]      shamt;
  logic               last_step;
  logic               early;
  logic               finish;
  logic               unused_flags;

  // Only CarryOut matters; the ALU's stale carry during PASS cycles must be masked.
  assign unused_flags = ^{alu_flags[3], alu_flags[1:0]};
  assign carry        = lo[0] & alu_flags[2];
  assign next_acc     = {carry, alu_out, lo[WIDTH-1:1]};

  assign last_step = (cnt == CW'(WIDTH - 1));
  assign early     = EARLY_EXIT && (lo[WIDTH-1:1] == '0);
  assign finish    = last_step || early;
  assign shamt     = CW'(WIDTH - 1) - cnt;
  assign final_acc = early ? (next_acc >> shamt) : next_acc;

  assign busy     = (state == STEP);
  assign alu_req  = (state == STEP);
  assign alu_e    = alu_req & alu_gnt;
  assign alu_mode = (state == STEP) ? (lo[0] ? MODE_ADD : MODE_PASS) : MODE_PASS;
  assign alu_op1  = (state == STEP) ? a  : '0;
  assign alu_op2  = (state == STEP) ? hi : '0;

  // Product is loaded on the final granted step so it is already valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      product   <= '0;
      prod_zero <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a     <= mcand;
            hi    <= '0;
            lo    <= mplier;
            cnt   <= '0;
            state <= STEP;
          end
        end
        STEP: begin
          if (alu_gnt) begin
            cnt <= cnt + CW'(1);
            {hi, lo} <= final_acc;
            if (finish) begin
              product   <= final_acc;
              prod_zero <= (final_acc == '0);
              done      <= 1'b1;
              state     <= DONE_S;
            end
          end
        end
        DONE_S: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
